// File: rtl/program_sequencer.sv
// Feeds a processor from a synchronous-read program memory: fetch, optional mvi immediate
// fetch, one run pulse per instruction, then wait on done. Stops on HALT or a done-timeout.
module program_sequencer #(
  parameter int REG_WIDTH         = 16,
  parameter int INSTRUCTION_WIDTH = 9,
  parameter int ADDR_WIDTH        = 8,
  parameter int TIMEOUT           = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [REG_WIDTH-1:0]  mem_data,
  input  logic                  done,
  output logic                  run,
  output logic [REG_WIDTH-1:0]  din,
  output logic                  busy,
  output logic                  halted,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_FETCH_IMM, S_LOAD_IMM, S_ISSUE, S_EXEC, S_HALT, S_ERR
  } state_t;

  state_t                       state, state_nx;
  logic [ADDR_WIDTH-1:0]        pc_nx, mem_addr_nx;
  logic                         mem_en_nx, run_nx;
  logic [REG_WIDTH-1:0]         din_nx, imm, imm_nx;
  logic [INSTRUCTION_WIDTH-1:0] instr, instr_nx;
  logic                         is_mvi, is_mvi_nx;
  logic [WD_W-1:0]              watchdog, watchdog_nx, wd_inc;
  logic [INSTRUCTION_WIDTH-1:0] fetched;
  logic [2:0]                   op;
  logic [ADDR_WIDTH-1:0]        pc_adv;

  assign fetched = mem_data[INSTRUCTION_WIDTH-1:0];
  assign op      = mem_data[INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH-3];
  assign wd_inc  = watchdog + WD_W'(1);
  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign pc_adv  = pc + (is_mvi ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));

  assign busy        = !(state inside {S_IDLE, S_HALT, S_ERR});
  assign halted      = (state == S_HALT);
  assign timeout_err = (state == S_ERR);

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    mem_en_nx   = 1'b0;
    mem_addr_nx = mem_addr;
    run_nx      = 1'b0;
    din_nx      = din;
    instr_nx    = instr;
    imm_nx      = imm;
    is_mvi_nx   = is_mvi;
    watchdog_nx = watchdog;
    case (state)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          state_nx    = S_FETCH;
          pc_nx       = '0;
          mem_en_nx   = 1'b1;
          mem_addr_nx = '0;
        end
      end
      S_FETCH: state_nx = S_LOAD;
      S_LOAD: begin
        instr_nx  = fetched;
        is_mvi_nx = (op == OP_MVI);
        if (op == OP_HALT) begin
          state_nx = S_HALT;
        end else if (op == OP_MVI) begin
          state_nx    = S_FETCH_IMM;
          mem_en_nx   = 1'b1;
          mem_addr_nx = pc + ADDR_WIDTH'(1);
        end else begin
          state_nx = S_ISSUE;
          run_nx   = 1'b1;
          din_nx   = REG_WIDTH'(fetched);
        end
      end
      S_FETCH_IMM: state_nx = S_LOAD_IMM;
      S_LOAD_IMM: begin
        imm_nx   = mem_data;
        state_nx = S_ISSUE;
        run_nx   = 1'b1;
        din_nx   = REG_WIDTH'(instr);
      end
      S_ISSUE: begin
        // The processor reads the immediate at T1, i.e. the cycle after run.
        state_nx    = S_EXEC;
        watchdog_nx = '0;
        if (is_mvi) din_nx = imm;
      end
      S_EXEC: begin
        if (done) begin
          state_nx    = S_FETCH;
          pc_nx       = pc_adv;
          mem_en_nx   = 1'b1;
          mem_addr_nx = pc_adv;
        end else begin
          watchdog_nx = wd_inc;
          if (wd_inc == WD_W'(TIMEOUT)) state_nx = S_ERR;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      run      <= 1'b0;
      din      <= '0;
      instr    <= '0;
      imm      <= '0;
      is_mvi   <= 1'b0;
      watchdog <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      mem_en   <= mem_en_nx;
      mem_addr <= mem_addr_nx;
      run      <= run_nx;
      din      <= din_nx;
      instr    <= instr_nx;
      imm      <= imm_nx;
      is_mvi   <= is_mvi_nx;
      watchdog <= watchdog_nx;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Random and directed programs run against a program-walking reference model; a
// behavioural memory and processor stand-in surround the sequencer.
module tb_program_sequencer;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst, start, done;
  logic        mem_en, run, busy, halted, timeout_err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_data, din;

  logic [15:0] mem [256];
  int          rd_log[$];
  int          exp_din0[$], exp_din1[$], exp_pc[$], exp_mvi[$], exp_rd[$];
  int          final_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  program_sequencer #(.REG_WIDTH(16), .INSTRUCTION_WIDTH(9), .ADDR_WIDTH(8),
                      .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .done(done), .run(run), .din(din), .busy(busy),
    .halted(halted), .timeout_err(timeout_err), .pc(pc)
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory; every read address is logged.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_data <= mem[mem_addr];
      rd_log.push_back(int'(mem_addr));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic [2:0] op);
    logic [15:0] w;
    w = 16'($urandom);
    w[8:6] = op;
    return w;
  endfunction

  function automatic logic [2:0] plain_op();
    int k;
    k = $urandom_range(0, 5);
    return (k == 0) ? 3'd0 : 3'(k + 1);
  endfunction

  // Reference: walk the program as the processor would see it.
  task automatic build_expect;
    int p;
    logic [15:0] w, imm;
    exp_din0.delete(); exp_din1.delete(); exp_pc.delete(); exp_mvi.delete(); exp_rd.delete();
    final_pc = -1;
    p = 0;
    for (int k = 0; k < 400; k++) begin
      w = mem[p];
      exp_rd.push_back(p);
      if (w[8:6] == 3'b111) begin
        final_pc = p;
        return;
      end
      exp_pc.push_back(p);
      exp_din0.push_back(int'(w[8:0]));
      if (w[8:6] == 3'b001) begin
        imm = mem[(p + 1) % 256];
        exp_rd.push_back((p + 1) % 256);
        exp_din1.push_back(int'(imm));
        exp_mvi.push_back(1);
        p = (p + 2) % 256;
      end else begin
        exp_din1.push_back(int'(w[8:0]));
        exp_mvi.push_back(0);
        p = (p + 1) % 256;
      end
    end
  endtask

  task automatic gen_prog(input int len);
    int a;
    a = 0;
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        mem[a] = word(3'b001);
        mem[a + 1] = 16'($urandom);
        a += 2;
      end else begin
        mem[a] = word(plain_op());
        a += 1;
      end
    end
    mem[a] = word(3'b111);
  endtask

  // Walks every address up to an mvi at 255 whose immediate is mem[0]; pc then
  // wraps to 1, where the first immediate doubles as a HALT.
  task automatic gen_wrap;
    int a;
    mem[0] = word(3'b001);
    mem[1] = word(3'b111);
    a = 2;
    while (a < 255) begin
      if (a <= 253 && $urandom_range(0, 2) == 0) begin
        mem[a] = word(3'b001);
        mem[a + 1] = 16'($urandom);
        a += 2;
      end else begin
        mem[a] = word(plain_op());
        a += 1;
      end
    end
    mem[255] = word(3'b001);
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (run !== 1'b1 && n < 20) begin
      tick;
      done = 1'b0;
      n++;
    end
    if (run !== 1'b1) n = -1;
  endtask

  // Starts the program and plays the processor, with random done delays and stray
  // done pulses in FETCH; hold_idx raises start during that instruction's EXEC.
  task automatic exec_prog(input int hold_idx);
    int n, d;
    build_expect();
    rd_log.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_flags", {halted, timeout_err}, 0);
    chk("start_pc", pc, 0);
    chk("start_mem", {mem_en, mem_addr}, {1'b1, 8'd0});
    for (int i = 0; i < exp_din0.size(); i++) begin
      wait_run(n);
      chk("run_latency", n, (exp_mvi[i] != 0) ? 4 : 2);
      if (n < 0) return;
      chk("din_issue", din, exp_din0[i]);
      chk("pc_issue", pc, exp_pc[i]);
      d = $urandom_range(1, 4);
      for (int j = 1; j <= d; j++) begin
        if (i == hold_idx) start = 1'b1;
        tick;
        chk("run_exec", run, 0);
        chk("din_exec", din, exp_din1[i]);
      end
      done = 1'b1;
      tick;
      start = 1'b0;
      done = 1'($urandom_range(0, 1));
    end
    tick;
    done = 1'b0;
    tick;
    chk("halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, final_pc);
    chk("halt_run", run, 0);
    tick;
    chk("halt_hold", {halted, run}, 2'b10);
    chk("rd_count", rd_log.size(), exp_rd.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      chk("rd_addr", rd_log[i], exp_rd[i]);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    rst = 1'b0; start = 1'b0; done = 1'b0;
    tick; tick;
    chk("rst_run", run, 0);
    chk("rst_din", din, 0);
    chk("rst_pc", pc, 0);
    chk("rst_mem", {mem_en, mem_addr}, 0);
    chk("rst_flags", {busy, halted, timeout_err}, 0);
    rst = 1'b1;
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("idle_done", {busy, pc}, 0);

    // mv R1,R0 then HALT
    mem[0] = 16'h0008; mem[1] = 16'h01C0;
    exec_prog(-1);

    // mvi R2,#0x1234 then HALT
    mem[0] = 16'h0050; mem[1] = 16'h1234; mem[2] = 16'h01C0;
    exec_prog(-1);

    // Reset during EXEC of the mvi, then a late done in IDLE.
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_run(n);
    chk("rst_mid_lat", n, 4);
    tick;
    chk("rst_mid_imm", din, 16'h1234);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("rst_mid_state", {busy, halted, timeout_err, run}, 0);
    chk("rst_mid_din", din, 0);
    chk("rst_mid_pc", pc, 0);
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("late_done", {busy, pc}, 0);

    // Watchdog: no done at all.
    mem[0] = 16'h0008; mem[1] = 16'h01C0;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_run(n);
    chk("to_lat", n, 2);
    for (int k = 0; k < TIMEOUT; k++) tick;
    chk("to_before", {timeout_err, busy}, 2'b01);
    tick;
    chk("to_err", {timeout_err, busy, run}, 3'b100);
    chk("to_pc", pc, 0);
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("to_hold", timeout_err, 1);
    exec_prog(-1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(3, 20);
      gen_prog(n);
      exec_prog($urandom_range(0, n - 1));
    end

    gen_wrap();
    exec_prog(-1);
    chk("wrap_pc", final_pc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
